// File: rtl/wieg_pkg.sv
// Shared definitions for the cradle rocking controller: state encoding,
// level width and the level-to-swing/level-to-duty mappings.
package wieg_pkg;

  localparam int NIVEAU_W = 3;
  localparam int TELLER_W = 16;
  localparam int PWM_W    = 8;

  typedef enum logic [1:0] {
    UIT    = 2'd0,
    WIEGEN = 2'd1,
    EVAL   = 2'd2,
    STOP   = 2'd3
  } toestand_t;

  function automatic logic [TELLER_W-1:0] half_len_van(
    input logic [NIVEAU_W-1:0] niv,
    input int                  basis,
    input int                  stap
  );
    int l;
    l = basis - int'(niv) * stap;
    return TELLER_W'(l);
  endfunction

  // Duty saturates at full scale so large steps never wrap to a low duty.
  function automatic logic [PWM_W-1:0] duty_van(
    input logic [NIVEAU_W-1:0] niv,
    input int                  dmin,
    input int                  dstap
  );
    int d;
    d = dmin + int'(niv) * dstap;
    if (d > 255) d = 255;
    return PWM_W'(d);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running 8-bit PWM: output high while enabled and the counter is below duty.
module pwm_gen
  import wieg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] duty,
  input  logic             enable,
  output logic             motor_pwm
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  // Combinational gate so dropping enable stops the motor in the same cycle.
  assign motor_pwm = enable && (pwm_cnt < duty);

endmodule

// File: rtl/wieg_aansturing.sv
// Cradle rocking-motor controller: adapts the rocking level from stress trend.
// Optional ZACHTE_START_EN: applied duty ramps from 0 and tracks target by +-1 per swing tick.
module wieg_aansturing
  import wieg_pkg::*;
#(
  parameter int NIVEAUS      = 8,
  parameter int START_NIVEAU = 3,
  parameter int BASIS_HALF   = 40,
  parameter int STAP_HALF    = 4,
  parameter int DUTY_MIN     = 64,
  parameter int DUTY_STAP    = 24,
  parameter int KALM_MAX     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tik_zwaai,
  input  logic                tik_eval,
  input  logic                start,
  input  logic                gedaald,
  input  logic                gelijk,
  output logic                motor_pwm,
  output logic                richting,
  output logic [NIVEAU_W-1:0] niveau,
  output logic                actief,
  output logic                klaar
);

  localparam logic [NIVEAU_W-1:0] NIV_MAX   = NIVEAU_W'(NIVEAUS - 1);
  localparam logic [NIVEAU_W-1:0] NIV_START = NIVEAU_W'(START_NIVEAU);
  localparam logic [7:0]          KALM_DOEL = 8'(KALM_MAX);

  if (NIVEAUS < 1 || NIVEAUS > 8) begin : g_chk_niveaus
    $error("wieg_aansturing: NIVEAUS must be in 1..8");
  end
  if (BASIS_HALF <= (NIVEAUS - 1) * STAP_HALF) begin : g_chk_half
    $error("wieg_aansturing: BASIS_HALF must exceed (NIVEAUS-1)*STAP_HALF");
  end

  toestand_t             toestand;
  logic [NIVEAU_W-1:0]   niveau_actief;
  logic [TELLER_W-1:0]   half_cnt;
  logic [TELLER_W-1:0]   half_len;
  logic [7:0]            kalm_cnt;
  logic                  grens;
  logic [NIVEAU_W-1:0]   niv_na;
  logic [7:0]            kalm_na;
  logic [PWM_W-1:0]      duty_doel;
  logic [PWM_W-1:0]      duty;

  assign half_len  = half_len_van(niveau_actief, BASIS_HALF, STAP_HALF);
  assign grens     = tik_zwaai && (half_cnt == half_len - TELLER_W'(1));
  assign duty_doel = duty_van(niveau_actief, DUTY_MIN, DUTY_STAP);

  // Outcome of one evaluation; gedaald wins over gelijk.
  always_comb begin
    niv_na  = niveau;
    kalm_na = kalm_cnt;
    if (gedaald) begin
      niv_na  = (niveau == '0) ? niveau : niveau - NIVEAU_W'(1);
      kalm_na = (kalm_cnt == KALM_DOEL) ? kalm_cnt : kalm_cnt + 8'd1;
    end else if (!gelijk) begin
      niv_na  = (niveau == NIV_MAX) ? niveau : niveau + NIVEAU_W'(1);
      kalm_na = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toestand      <= UIT;
      actief        <= 1'b0;
      klaar         <= 1'b0;
      richting      <= 1'b0;
      niveau        <= '0;
      niveau_actief <= '0;
      half_cnt      <= '0;
      kalm_cnt      <= '0;
    end else begin
      klaar <= 1'b0;
      // The swing runs in every non-idle state, EVAL included.
      if (toestand != UIT && tik_zwaai) begin
        if (grens) begin
          half_cnt      <= '0;
          richting      <= ~richting;
          niveau_actief <= niveau;
        end else begin
          half_cnt <= half_cnt + TELLER_W'(1);
        end
      end
      case (toestand)
        UIT: begin
          if (start) begin
            toestand      <= WIEGEN;
            actief        <= 1'b1;
            niveau        <= NIV_START;
            niveau_actief <= NIV_START;
            richting      <= 1'b0;
            half_cnt      <= '0;
            kalm_cnt      <= '0;
          end
        end
        WIEGEN: begin
          if (!start)        toestand <= STOP;
          else if (tik_eval) toestand <= EVAL;
        end
        EVAL: begin
          niveau   <= niv_na;
          kalm_cnt <= kalm_na;
          if (gedaald && kalm_na == KALM_DOEL && niv_na == '0) toestand <= STOP;
          else                                                  toestand <= WIEGEN;
        end
        STOP: begin
          if (grens) begin
            toestand <= UIT;
            actief   <= 1'b0;
            klaar    <= 1'b1;
          end
        end
        default: toestand <= UIT;
      endcase
    end
  end

`ifdef ZACHTE_START_EN
  logic [PWM_W-1:0] duty_zacht;

  always_ff @(posedge clk) begin
    if (reset || toestand == UIT) begin
      duty_zacht <= '0;
    end else if (tik_zwaai) begin
      if (duty_zacht < duty_doel)      duty_zacht <= duty_zacht + PWM_W'(1);
      else if (duty_zacht > duty_doel) duty_zacht <= duty_zacht - PWM_W'(1);
    end
  end

  assign duty = duty_zacht;
`else
  assign duty = duty_doel;
`endif

  pwm_gen u_pwm (
    .clk       (clk),
    .reset     (reset),
    .duty      (duty),
    .enable    (actief),
    .motor_pwm (motor_pwm)
  );

endmodule

// File: tb/tb_wieg_aansturing.sv
// Scoreboard bench for wieg_aansturing: directed stimulus queues expected
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_wieg_aansturing;

  logic       clk = 1'b0;
  logic       reset, tik_zwaai, tik_eval, start, gedaald, gelijk;
  logic       motor_pwm, richting, actief, klaar;
  logic [2:0] niveau;

  always #5 clk = ~clk;

  wieg_aansturing dut (
    .clk       (clk),
    .reset     (reset),
    .tik_zwaai (tik_zwaai),
    .tik_eval  (tik_eval),
    .start     (start),
    .gedaald   (gedaald),
    .gelijk    (gelijk),
    .motor_pwm (motor_pwm),
    .richting  (richting),
    .niveau    (niveau),
    .actief    (actief),
    .klaar     (klaar)
  );

  typedef enum int {EV_AAN, EV_UIT, EV_NIV, EV_RICH, EV_KLAAR} ev_soort_t;
  typedef struct {
    ev_soort_t soort;
    int        waarde;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fouten = 0;

  function automatic void verwacht(input ev_soort_t s, input int w);
    ev_t e;
    e.soort  = s;
    e.waarde = w;
    sb.push_back(e);
  endfunction

  function automatic void vergelijk_ev(input ev_soort_t s, input int w);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fouten++;
      $display("FAIL unexpected_event: got %s=%0d, required no event", s.name(), w);
    end else begin
      e = sb.pop_front();
      if (e.soort != s || e.waarde != w) begin
        n_fouten++;
        $display("FAIL event: got %s=%0d, required %s=%0d", s.name(), w, e.soort.name(), e.waarde);
      end
    end
  endfunction

  function automatic void check_direct(input string naam, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fouten++;
      $display("FAIL %s: got %0d, required %0d", naam, got, exp);
    end
  endfunction

  // Monitor: turns output changes into events; counts swing ticks per half-swing.
  logic       p_actief = 1'b0, p_richting = 1'b0;
  logic [2:0] p_niveau = 3'd0;
  int         ticks = 0;

  always @(negedge clk) begin
    if (actief != p_actief) begin
      if (actief) begin
        ticks = 0;
        vergelijk_ev(EV_AAN, int'(niveau));
      end else begin
        vergelijk_ev(EV_UIT, 0);
      end
    end
    if (p_actief && actief && niveau != p_niveau) vergelijk_ev(EV_NIV, int'(niveau));
    if (p_actief && richting != p_richting && (actief || klaar)) begin
      vergelijk_ev(EV_RICH, ticks);
      ticks = 0;
    end
    if (klaar) vergelijk_ev(EV_KLAAR, 1);
    if (tik_zwaai) ticks++;
    p_actief   = actief;
    p_richting = richting;
    p_niveau   = niveau;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic zwaai(input int n);
    repeat (n) begin
      tik_zwaai = 1'b1;
      cyc(1);
      tik_zwaai = 1'b0;
      cyc(1);
    end
  endtask

  task automatic evalueer(input logic g, input logic l, input logic met_tik);
    gedaald   = g;
    gelijk    = l;
    tik_eval  = 1'b1;
    tik_zwaai = met_tik;
    cyc(1);
    tik_eval  = 1'b0;
    tik_zwaai = 1'b0;
    cyc(1);
    gedaald   = 1'b0;
    gelijk    = 1'b0;
    cyc(1);
  endtask

  task automatic duty_meet(input string naam, input int exp);
    int n;
    n = 0;
    repeat (256) begin
      if (motor_pwm) n++;
      cyc(1);
    end
    check_direct(naam, n, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tik_zwaai = 1'b0; tik_eval = 1'b0;
    start = 1'b0; gedaald = 1'b0; gelijk = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check_direct("reset_outputs", int'({actief, klaar, motor_pwm, richting, niveau}), 0);

    // Start at level 3: half-swing of 28 ticks, duty 136/256.
    verwacht(EV_AAN, 3);
    start = 1'b1;
    cyc(2);
    check_direct("start_actief", int'(actief), 1);
    check_direct("start_niveau", int'(niveau), 3);
    verwacht(EV_RICH, 28);
    verwacht(EV_RICH, 28);
    zwaai(56);
    duty_meet("duty_lvl3", 136);

    // Drop start at tick 10, reassert during STOP: the half-swing completes, then UIT.
    verwacht(EV_UIT, 0);
    verwacht(EV_RICH, 28);
    verwacht(EV_KLAAR, 1);
    zwaai(10);
    start = 1'b0;
    cyc(2);
    start = 1'b1;
    zwaai(17);
    start = 1'b0;
    zwaai(1);
    cyc(3);
    check_direct("uit_actief", int'(actief), 0);
    check_direct("uit_pwm", int'(motor_pwm), 0);

    // Rising stress: level steps up, half_len changes only at a boundary.
    verwacht(EV_AAN, 3);
    start = 1'b1;
    cyc(2);
    zwaai(5);
    verwacht(EV_NIV, 4);
    evalueer(1'b0, 1'b0, 1'b0);
    verwacht(EV_RICH, 28);
    zwaai(23);
    verwacht(EV_RICH, 24);
    zwaai(24);
    verwacht(EV_NIV, 5);
    verwacht(EV_NIV, 6);
    evalueer(1'b0, 1'b0, 1'b0);
    evalueer(1'b0, 1'b0, 1'b0);
    verwacht(EV_RICH, 24);
    zwaai(24);
    verwacht(EV_RICH, 16);
    zwaai(16);
    duty_meet("duty_lvl6", 208);
    verwacht(EV_NIV, 7);
    evalueer(1'b0, 1'b0, 1'b0);
    evalueer(1'b0, 1'b0, 1'b0);
    evalueer(1'b0, 1'b0, 1'b0);
    evalueer(1'b0, 1'b1, 1'b0);
    verwacht(EV_RICH, 16);
    zwaai(16);
    verwacht(EV_RICH, 12);
    zwaai(12);
    duty_meet("duty_lvl7", 232);

    // Reset mid-swing: outputs clear next cycle, no klaar.
    zwaai(5);
    verwacht(EV_UIT, 0);
    reset = 1'b1;
    start = 1'b0;
    cyc(1);
    reset = 1'b0;
    check_direct("reset_midswing", int'({actief, klaar, motor_pwm, richting, niveau}), 0);
    cyc(3);

    // Calming: priority of gedaald, kalm_cnt cleared by a rise, stop after 4 more gedaald.
    verwacht(EV_AAN, 3);
    start = 1'b1;
    cyc(2);
    verwacht(EV_NIV, 2);
    evalueer(1'b1, 1'b1, 1'b0);
    verwacht(EV_NIV, 1);
    evalueer(1'b1, 1'b0, 1'b0);
    verwacht(EV_NIV, 2);
    evalueer(1'b0, 1'b0, 1'b0);
    verwacht(EV_NIV, 1);
    evalueer(1'b1, 1'b0, 1'b0);
    verwacht(EV_NIV, 0);
    evalueer(1'b1, 1'b0, 1'b0);
    verwacht(EV_RICH, 28);
    zwaai(28);
    evalueer(1'b1, 1'b0, 1'b0);
    evalueer(1'b1, 1'b0, 1'b1);
    evalueer(1'b0, 1'b0, 1'b0);
    verwacht(EV_UIT, 0);
    verwacht(EV_RICH, 40);
    verwacht(EV_KLAAR, 1);
    zwaai(38);
    start = 1'b0;
    zwaai(1);
    cyc(3);
    check_direct("kalm_uit_actief", int'(actief), 0);
    check_direct("kalm_niveau", int'(niveau), 0);
    check_direct("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fouten);
    $finish;
  end

endmodule
